// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states, lane widths.
package dmem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I loads/stores: byte enables, store shifting, load extension, error.
// DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors instead of masking.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic            we,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    input  logic [31:0]     wdata,
    input  logic [31:0]     rword,
    output logic [BE_W-1:0] be,
    output logic [31:0]     wdata_sh,
    output logic [31:0]     rdata,
    output logic            err
);
    logic [1:0]  eff;
    logic [31:0] sh;
    logic        is_b, is_h, is_w, uns;

    always_comb begin
        is_b = (funct3 == F3_B) || (funct3 == F3_BU);
        is_h = (funct3 == F3_H) || (funct3 == F3_HU);
        is_w = (funct3 == F3_W);
        uns  = funct3[2];
        err  = !(is_b || is_h || is_w) || (we && uns);
        eff  = off;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((is_h && off[0]) || (is_w && off != 2'b00))
            err = 1'b1;
`else
        if (is_h) eff = {off[1], 1'b0};
        if (is_w) eff = 2'b00;
`endif
        sh       = rword >> {eff, 3'b000};
        be       = '0;
        wdata_sh = '0;
        rdata    = '0;
        if (is_b) begin
            be       = BE_W'(4'b0001 << eff);
            wdata_sh = {4{wdata[7:0]}};
            rdata    = uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        end else if (is_h) begin
            be       = BE_W'(4'b0011 << eff);
            wdata_sh = {2{wdata[15:0]}};
            rdata    = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        end else if (is_w) begin
            be       = '1;
            wdata_sh = wdata;
            rdata    = sh;
        end
        // Rejected accesses neither write nor return data.
        if (err) begin
            be    = '0;
            rdata = '0;
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, programmable wait states, held response.
// Optional misaligned-access trapping via DMEM_MISALIGN_TRAP_EN (see dmem_lane_align).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           lat_we;
    logic [AW+1:0]  lat_addr;
    logic [2:0]     lat_f3;
    logic [31:0]    lat_wdata;

    logic [31:0]    mem [DEPTH_WORDS];
    logic [AW-1:0]  idx;
    logic [BE_W-1:0] be;
    logic [31:0]    wdata_sh, ld_data;
    logic           acc_err, access;

    assign idx    = lat_addr[AW+1:2];
    assign access = (state == WAIT) && (cnt == '0);

    dmem_lane_align u_align (
        .we       (lat_we),
        .off      (lat_addr[1:0]),
        .funct3   (lat_f3),
        .wdata    (lat_wdata),
        .rword    (mem[idx]),
        .be       (be),
        .wdata_sh (wdata_sh),
        .rdata    (ld_data),
        .err      (acc_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_f3    <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr[AW+1:0];
                        lat_f3    <= req_funct3;
                        lat_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        cnt       <= CW'(WAIT_CYCLES);
                        state     <= WAIT;
                    end
                end
                // Counter expiry is the access edge, giving accept-to-valid of 1+WAIT_CYCLES.
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || lat_we) ? 32'd0 : ld_data;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is not reset; reset forces IDLE so a pending store never lands.
    always_ff @(posedge clk) begin
        if (access && lat_we && !rst) begin
            for (int i = 0; i < BE_W; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed table-driven bench for dmem_responder plus reset/backpressure sequences.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam logic [31:0] W10      = 32'hDEAD55EF;
    localparam logic        MIS_ERR  = 1'b1;
    localparam logic [31:0] LHU11    = 32'h0;
`else
    localparam logic [31:0] W10      = 32'hA5A5A5A5;
    localparam logic        MIS_ERR  = 1'b0;
    localparam logic [31:0] LHU11    = 32'h0000A5A5;
`endif

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(logic we, logic [31:0] a, logic [2:0] f3, logic [31:0] wd,
                                logic [31:0] er, logic ee);
        vec_t v;
        v.we = we; v.addr = a; v.f3 = f3; v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // Present a request and return once it has been accepted on a rising edge.
    task automatic issue(input logic we, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] wd, output logic ok);
        int n = 0;
        ok = 1'b0;
        while (n < 50) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
        end
        if (n >= 50) begin
            chk("req_ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_valid = 1'b1; req_we = we; req_addr = a; req_funct3 = f3; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        ok = 1'b1;
    endtask

    // Count rising edges from accept until rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (lat < 20) begin
            if (lat > 0 || 1'b1) begin
                @(posedge clk);
                lat++;
                #1;
                if (rsp_valid) break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic ok;
        int   lat;
        issue(v.we, v.addr, v.f3, v.wdata, ok);
        if (!ok) return;
        wait_rsp(lat);
        chk({nm, "_lat"}, 32'(lat), 32'd3);
        chk({nm, "_rdata"}, rsp_rdata, v.exp_rdata);
        chk({nm, "_err"}, 32'(rsp_err), 32'(v.exp_err));
        @(posedge clk);
        #1;
        chk({nm, "_done"}, {30'd0, rsp_valid, req_ready}, 32'b01);
    endtask

    initial begin
        logic        ok;
        int          lat;
        logic [31:0] held;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_funct3 = '0; req_wdata = '0; rsp_ready = 1'b1;

        vecs.push_back(mk(1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0));
        vecs.push_back(mk(0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 32'h13, 3'b000, 32'h0, 32'hFFFFFFDE, 0));
        vecs.push_back(mk(0, 32'h13, 3'b100, 32'h0, 32'h000000DE, 0));
        vecs.push_back(mk(0, 32'h12, 3'b001, 32'h0, 32'hFFFFDEAD, 0));
        vecs.push_back(mk(0, 32'h10, 3'b101, 32'h0, 32'h0000BEEF, 0));
        vecs.push_back(mk(1, 32'h11, 3'b000, 32'h00000055, 32'h0, 0));
        vecs.push_back(mk(0, 32'h10, 3'b010, 32'h0, 32'hDEAD55EF, 0));
        vecs.push_back(mk(0, 32'h10, 3'b011, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 32'h12, 3'b010, 32'hA5A5A5A5, 32'h0, MIS_ERR));
        vecs.push_back(mk(0, 32'h10, 3'b010, 32'h0, W10, 0));
        vecs.push_back(mk(0, 32'h11, 3'b101, 32'h0, LHU11, MIS_ERR));
        vecs.push_back(mk(0, 32'h1010, 3'b010, 32'h0, W10, 0));
        vecs.push_back(mk(1, 32'h14, 3'b010, 32'h0, 32'h0, 0));
        vecs.push_back(mk(1, 32'h16, 3'b001, 32'h1234ABCD, 32'h0, 0));
        vecs.push_back(mk(0, 32'h14, 3'b010, 32'h0, 32'hABCD0000, 0));
        vecs.push_back(mk(0, 32'h16, 3'b000, 32'h0, 32'hFFFFFFCD, 0));
        vecs.push_back(mk(0, 32'h17, 3'b100, 32'h0, 32'h000000AB, 0));
        vecs.push_back(mk(0, 32'h14, 3'b001, 32'h0, 32'h0, 0));
        vecs.push_back(mk(1, 32'h14, 3'b100, 32'hFFFFFFFF, 32'h0, 1));
        vecs.push_back(mk(1, 32'h14, 3'b111, 32'hFFFFFFFF, 32'h0, 1));
        vecs.push_back(mk(0, 32'h14, 3'b110, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 32'h14, 3'b010, 32'h0, 32'hABCD0000, 0));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_rst", 32'(req_ready), 32'd1);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: response must hold while rsp_ready is low
        rsp_ready = 1'b0;
        issue(1'b0, 32'h14, 3'b010, 32'h0, ok);
        if (ok) begin
            wait_rsp(lat);
            chk("bp_lat", 32'(lat), 32'd3);
            held = rsp_rdata;
            chk("bp_rdata", held, 32'hABCD0000);
            for (int k = 0; k < 5; k++) begin
                @(posedge clk);
                #1;
                chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
                chk("bp_hold_rdata", rsp_rdata, held);
                chk("bp_hold_ready", 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_release_valid", 32'(rsp_valid), 32'd0);
            chk("bp_release_ready", 32'(req_ready), 32'd1);
        end

        // Reset during WAIT drops the store
        run_vec(mk(1, 32'h20, 3'b010, 32'h11112222, 32'h0, 0), "pre20");
        issue(1'b1, 32'h20, 3'b010, 32'h12345678, ok);
        if (ok) begin
            @(posedge clk);
            #2 rst = 1'b1;
            #1;
            chk("midrst_req_ready", 32'(req_ready), 32'd0);
            chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
            repeat (4) @(posedge clk);
            #1 chk("midrst_hold_valid", 32'(rsp_valid), 32'd0);
            @(negedge clk) rst = 1'b0;
        end
        run_vec(mk(0, 32'h20, 3'b010, 32'h0, 32'h11112222, 0), "post20");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
